// File: rtl/adc_frame_serializer.sv
// Serializes up to CHANNELS parallel WIDTH-bit samples onto one bit line with a
// one-hot channel enable, one burst per start request, in ascending channel order.
module adc_frame_serializer #(
    parameter int CHANNELS   = 8,
    parameter int WIDTH      = 10,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [CHANNELS*WIDTH-1:0] samples,
    input  logic [CHANNELS-1:0]       chan_mask,
    output logic                      bit_out,
    output logic [CHANNELS-1:0]       adc_en,
    output logic                      busy,
    output logic                      done
);

    localparam int CH_W  = (CHANNELS > 1)   ? $clog2(CHANNELS)   : 1;
    localparam int CNT_W = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    typedef struct packed {
        logic            found;
        logic [CH_W-1:0] idx;
    } pick_t;

    // Lowest set mask bit at or above index 'from'.
    function automatic pick_t lowest_set(input logic [CHANNELS-1:0] mask, input int from);
        pick_t p;
        p = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) begin
                p.found = 1'b1;
                p.idx   = CH_W'(i);
            end
        end
        return p;
    endfunction

    state_t             r_state;
    logic [CH_W-1:0]    r_ch;
    logic [CNT_W-1:0]   r_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic [CHANNELS-1:0] r_mask;
    logic [WIDTH-1:0]   r_shadow [CHANNELS];
    logic               r_bit_out;
    logic [CHANNELS-1:0] r_adc_en;
    logic               r_busy;
    logic               r_done;

    state_t             w_state_nxt;
    logic [CH_W-1:0]    w_ch_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_done_nxt;
    logic               w_capture;
    pick_t              w_first;
    pick_t              w_next;
    logic [WIDTH-1:0]   w_in [CHANNELS];
    logic [WIDTH-1:0]   w_word;
    logic [CNT_W-1:0]   w_bit_idx;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_in[c] = samples[c*WIDTH +: WIDTH];
        end
    end

    assign w_first = lowest_set(chan_mask, 0);
    assign w_next  = lowest_set(r_mask, int'(r_ch) + 1);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_done_nxt  = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_capture = 1'b1;
                    if (w_first.found) begin
                        w_state_nxt = SHIFT;
                        w_ch_nxt    = w_first.idx;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_cnt_nxt = '0;
                    if (!w_next.found) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        // Next channel is latched now so GAP only has to count.
                        w_ch_nxt = w_next.idx;
                        if (GAP_CYCLES > 0) begin
                            w_state_nxt = GAP;
                            w_gap_nxt   = '0;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = SHIFT;
                end else begin
                    w_gap_nxt = r_gap + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state values, so the sample word must
    // come straight from the input bus on the capture edge.
    assign w_word    = w_capture ? w_in[w_ch_nxt] : r_shadow[w_ch_nxt];
    assign w_bit_idx = (MSB_FIRST != 0) ? (CNT_W'(WIDTH - 1) - w_cnt_nxt) : w_cnt_nxt;

    // NOTE: state registers use non-blocking assignments so all updates land together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_mask    <= '0;
            // NOTE: the shadow bank is small register storage, not RAM, so it can be cleared on reset.
            for (int c = 0; c < CHANNELS; c++) begin
                r_shadow[c] <= '0;
            end
            r_bit_out <= 1'b0;
            r_adc_en  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            if (w_capture) begin
                r_mask <= chan_mask;
                for (int c = 0; c < CHANNELS; c++) begin
                    r_shadow[c] <= w_in[c];
                end
            end
            r_bit_out <= (w_state_nxt == SHIFT) ? w_word[w_bit_idx] : 1'b0;
            r_adc_en  <= (w_state_nxt == SHIFT) ? (CHANNELS'(1) << w_ch_nxt) : '0;
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= w_done_nxt;
        end
    end

    assign bit_out = r_bit_out;
    assign adc_en  = r_adc_en;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Scoreboard bench: dut0 runs back-to-back channels, dut1 inserts 3-cycle gaps.
module tb_adc_frame_serializer;

    localparam int CH  = 8;
    localparam int W   = 10;
    localparam int GAP = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [1:0]             start_v;
    logic [1:0][CH*W-1:0]   samp_v;
    logic [1:0][CH-1:0]     mask_v;
    logic [1:0]             bit_v;
    logic [1:0][CH-1:0]     en_v;
    logic [1:0]             busy_v;
    logic [1:0]             done_v;

    adc_frame_serializer #(.CHANNELS(CH), .WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .samples(samp_v[0]), .chan_mask(mask_v[0]),
        .bit_out(bit_v[0]), .adc_en(en_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    adc_frame_serializer #(.CHANNELS(CH), .WIDTH(W), .MSB_FIRST(1), .GAP_CYCLES(GAP)) dut_gap (
        .clk(clk), .rst(rst), .start(start_v[1]), .samples(samp_v[1]), .chan_mask(mask_v[1]),
        .bit_out(bit_v[1]), .adc_en(en_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    always #5 clk = ~clk;

    typedef struct { int dut; int ch; logic [W-1:0] word; } word_t;
    typedef struct { int dut; int len; int gaps; } frame_t;

    word_t  exp_q[$];
    frame_t frame_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    logic [W-1:0] cap [2][CH];
    int nbits [2];
    int cur_ch [2];
    int busy_cnt [2];
    int gap_cnt [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [CH*W-1:0] rand_samples();
        logic [CH*W-1:0] s;
        for (int c = 0; c < CH; c++) s[c*W +: W] = W'($urandom);
        return s;
    endfunction

    // Model: expected channel words in ascending order plus frame length.
    task automatic launch(input int d, input logic [CH-1:0] mask, input logic [CH*W-1:0] samp);
        int k;
        int g;
        k = 0;
        for (int c = 0; c < CH; c++) begin
            if (mask[c]) begin
                exp_q.push_back('{dut: d, ch: c, word: samp[c*W +: W]});
                k++;
            end
        end
        g = (k > 0) ? (k - 1) * ((d == 1) ? GAP : 0) : 0;
        frame_q.push_back('{dut: d, len: k * W + g, gaps: g});
        start_v[d] = 1'b1;
        samp_v[d]  = samp;
        mask_v[d]  = mask;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int limit);
        for (int i = 0; i < limit && !done_v[d]; i++) @(negedge clk);
        check("done_seen", done_v[d], 1);
    endtask

    task automatic check_quiet(input int d, input string tag);
        check({tag, "_busy"}, busy_v[d], 0);
        check({tag, "_en"},   en_v[d],   0);
        check({tag, "_bit"},  bit_v[d],  0);
        check({tag, "_done"}, done_v[d], 0);
    endtask

    // Receive side: capture registers, word pop/compare, frame length on done.
    initial begin : monitor
        word_t  w;
        frame_t f;
        int     ch;
        for (int d = 0; d < 2; d++) begin
            nbits[d] = 0; cur_ch[d] = 0; busy_cnt[d] = 0; gap_cnt[d] = 0;
            for (int c = 0; c < CH; c++) cap[d][c] = '0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    nbits[d] = 0; busy_cnt[d] = 0; gap_cnt[d] = 0;
                end else begin
                    if (busy_v[d]) begin
                        busy_cnt[d]++;
                        if (en_v[d] == '0) gap_cnt[d]++;
                    end
                    if (en_v[d] != '0) begin
                        check("en_onehot", $countones(en_v[d]), 1);
                        check("busy_with_en", busy_v[d], 1);
                        ch = 0;
                        for (int c = 0; c < CH; c++) if (en_v[d][c]) ch = c;
                        if (nbits[d] != 0 && ch != cur_ch[d]) begin
                            check("partial_word", nbits[d], W);
                            nbits[d] = 0;
                        end
                        cur_ch[d] = ch;
                        cap[d][ch] = {cap[d][ch][W-2:0], bit_v[d]};
                        nbits[d]++;
                        if (nbits[d] == W) begin
                            nbits[d] = 0;
                            if (exp_q.size() == 0) begin
                                check("unexpected_word", 1, 0);
                            end else begin
                                w = exp_q.pop_front();
                                check("word_dut", d, w.dut);
                                check("word_ch", ch, w.ch);
                                check("word_val", cap[d][ch], w.word);
                            end
                        end
                    end else begin
                        check("bit_when_no_en", bit_v[d], 0);
                    end
                    if (done_v[d]) begin
                        check("done_busy_low", busy_v[d], 0);
                        check("done_partial", nbits[d], 0);
                        if (frame_q.size() == 0) begin
                            check("unexpected_done", 1, 0);
                        end else begin
                            f = frame_q.pop_front();
                            check("frame_dut", d, f.dut);
                            check("frame_len", busy_cnt[d], f.len);
                            check("frame_gaps", gap_cnt[d], f.gaps);
                        end
                        busy_cnt[d] = 0;
                        gap_cnt[d]  = 0;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [CH*W-1:0] s1, s2, s3, s4, s5, s6, s7;
        start_v = '0;
        samp_v  = '0;
        mask_v  = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet(0, "rst0");
        check_quiet(1, "rst1");
        rst = 1'b0;
        @(negedge clk);

        // All eight channels, back to back.
        for (int c = 0; c < CH; c++) s1[c*W +: W] = W'(c * 10'h041 + 10'h001);
        launch(0, 8'hFF, s1);
        check("latency_en", en_v[0], 8'h01);
        check("latency_busy", busy_v[0], 1);
        wait_done(0, 100);
        @(negedge clk);
        check("done_single", done_v[0], 0);

        // Sparse mask: only ch2/5/7 move, the rest keep the previous frame.
        s2 = rand_samples();
        s2[2*W +: W] = 10'h3FF;
        s2[5*W +: W] = 10'h155;
        s2[7*W +: W] = 10'h2AA;
        launch(0, 8'b1010_0100, s2);
        check("sparse_first_en", en_v[0], 8'h04);
        wait_done(0, 100);
        check("cap_ch2", cap[0][2], 10'h3FF);
        check("cap_ch5", cap[0][5], 10'h155);
        check("cap_ch7", cap[0][7], 10'h2AA);
        for (int c = 0; c < CH; c++)
            if (c == 0 || c == 1 || c == 3 || c == 4 || c == 6)
                check("cap_untouched", cap[0][c], W'(c * 10'h041 + 10'h001));

        // Empty mask: immediate done, nothing else moves.
        @(negedge clk);
        launch(0, 8'h00, s1);
        check("empty_done", done_v[0], 1);
        check("empty_busy", busy_v[0], 0);
        check("empty_en", en_v[0], 0);
        @(negedge clk);
        check("empty_done_pulse", done_v[0], 0);

        // Mid-frame start and input changes are ignored and not queued.
        s3 = rand_samples();
        launch(0, 8'h81, s3);
        repeat (5) @(negedge clk);
        start_v[0] = 1'b1;
        samp_v[0]  = ~s3;
        mask_v[0]  = 8'hFF;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 60);
        repeat (2) begin
            @(negedge clk);
            check("start_not_queued", busy_v[0], 0);
        end

        // Start coincident with done launches the next frame one cycle later.
        s4 = rand_samples();
        launch(0, 8'h10, s4);
        wait_done(0, 40);
        s5 = rand_samples();
        launch(0, 8'h22, s5);
        check("b2b_busy", busy_v[0], 1);
        check("b2b_en", en_v[0], 8'h02);
        wait_done(0, 40);

        // Gap instance: 10 bits, 3 idle busy cycles, 10 bits.
        @(negedge clk);
        s6 = rand_samples();
        launch(1, 8'h03, s6);
        check("gap_first_en", en_v[1], 8'h01);
        wait_done(1, 60);

        // Asynchronous reset at ch3 bit 4 abandons the frame without done.
        @(negedge clk);
        launch(0, 8'hFF, s1);
        repeat (34) @(negedge clk);
        check("pre_rst_en", en_v[0], 8'h08);
        check("pre_rst_busy", busy_v[0], 1);
        #2 rst = 1'b1;
        #1 check_quiet(0, "async_rst");
        exp_q.delete();
        frame_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("no_done_after_rst", done_v[0], 0);
        end
        s7 = rand_samples();
        launch(0, 8'h08, s7);
        check("post_rst_en", en_v[0], 8'h08);
        wait_done(0, 30);
        @(negedge clk);

        check("exp_q_empty", exp_q.size(), 0);
        check("frame_q_empty", frame_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_serializer.md
Name: adc_frame_serializer

Overview:
- Transmit end of the per-channel ADC capture bus.
- Takes up to 8 parallel 10-bit samples and shifts them out on a single serial bit line, with a one-hot channel enable alongside.
- On the receive side, each enable selects which 10-bit capture register the bit is shifted into.
- Sits between the sample source (test pattern or digital front-end) and the channel capture registers, and frames one burst per start request.

Parameters:
- CHANNELS, 8: number of channels; width of the one-hot enable and of the mask.
- WIDTH, 10: bits per channel sample.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- GAP_CYCLES, 0: idle cycles inserted between consecutive transmitted channels; 0 means back-to-back.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a frame; sampled only in IDLE.
- samples  input  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH+WIDTH-1 : c*WIDTH].
- chan_mask  input  CHANNELS  1 = transmit that channel; 0 = skip it.
- bit_out  output  1  serial data.
- adc_en  output  CHANNELS  one-hot enable of the channel whose bit is on bit_out; all-zero when no bit is valid.
- busy  output  1  high while a frame is in progress.
- done  output  1  single-cycle pulse at end of frame.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- All outputs are registered.
- Reset, asserted at any time including mid-frame: state goes to IDLE, and bit_out, adc_en, busy and done go to 0 immediately. Shadow registers and counters clear. A partially sent channel is abandoned, with no done pulse.
- States: IDLE, SHIFT, GAP.
- IDLE: outputs are 0.
  - On a clk edge with start=1, capture samples and chan_mask into shadow registers.
  - If the captured mask is nonzero: go to SHIFT with ch = lowest set mask bit, bit counter = 0.
  - If the captured mask is 0: stay in IDLE and pulse done for one cycle. busy stays 0.
- SHIFT:
  - adc_en = 1<<ch and busy = 1.
  - bit_out = shadow sample ch, bit (WIDTH-1-cnt) when MSB_FIRST=1, or bit cnt when MSB_FIRST=0.
  - The counter increments each cycle; a channel lasts exactly WIDTH cycles.
  - On the last bit, cnt=WIDTH-1:
    - If no set mask bit exists above ch: go to IDLE, done=1 for the following cycle, busy=0 in that same cycle.
    - Otherwise, if GAP_CYCLES>0: go to GAP.
    - Otherwise: go to SHIFT with ch = the next set mask bit and cnt=0, with no bubble.
- GAP:
  - adc_en=0, bit_out=0, busy=1.
  - Lasts exactly GAP_CYCLES cycles, then goes to SHIFT with the next set channel.
- Latency: with start sampled at edge N, the first bit and its adc_en are valid from edge N+1.
- Frame length: busy is high for k*WIDTH + (k-1)*GAP_CYCLES cycles, where k = popcount(mask).
- Boundary conditions:
  - Channels are always sent in ascending index order.
  - Masked-off channels take zero cycles.
  - start while busy (SHIFT or GAP) is ignored and not queued.
  - start asserted in the same cycle done is high is accepted, because the state is IDLE. This allows back-to-back frames with one idle cycle between them.
  - Changes to samples or chan_mask during a frame have no effect; the shadow copies are used.
  - adc_en is never multi-hot. bit_out is 0 whenever adc_en is 0.
  - The channel index and counter are sized as clog2(CHANNELS) and clog2(WIDTH) bits. There is no wrap: the last channel always terminates the frame.

Test Plan:
- Reset release; start=1, mask=8'hFF, sample c = c*10'h041+10'h001 -> 80 cycles of busy. adc_en walks 01,02,...,80, 10 cycles each. Bits are MSB first. A bench capture register bank reproduces all 8 samples. done pulses once at cycle 81.
- mask=8'b1010_0100, samples 10'h3FF/10'h155/10'h2AA on ch2/5/7 -> only adc_en 04, 20, 80 appear. busy=30 cycles. Captured values match; other channels are untouched.
- GAP_CYCLES=3, mask=8'h03 -> 10 bits on ch0, then 3 cycles with adc_en=0 and bit_out=0 while busy=1, then 10 bits on ch1. busy=23 cycles.
- mask=0 with start -> done pulses one cycle after start. busy and adc_en stay 0.
- start re-pulsed mid-frame, and samples changed mid-frame -> no effect on the current frame. A start coincident with done launches a new frame exactly 1 cycle later.
- rst asserted asynchronously at bit 4 of ch3 -> outputs go to 0 before the next edge, with no done pulse. After release, a fresh start with mask=8'h08 sends ch3 completely.
